// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences WB exceptions, interrupts and MRET into
// flush -> (drain) -> commit -> fetch redirect.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   exc_*, mret_req,   WB-stage events
//   wb_valid, wb_pc
//   irq_*, mtvec, mepc CSR-unit inputs
//   mem_busy           data-bus transaction outstanding
//   redirect_ready     fetch accepts redirect
//   trap_*, mret       commit pulses to CSR unit
//   wb_kill, flush     pipeline control
//   redirect_*, busy   fetch redirect, controller active
module trap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        irq_pending,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mem_busy,
  input  logic        redirect_ready,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_val,
  output logic [31:0] trap_pc,
  output logic        mret,
  output logic        wb_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, DRAIN, COMMIT, REDIRECT
  } state_e;

  state_e      state_q, state_d;
  logic        is_mret_q;
  logic [31:0] cause_q, val_q, pc_q, rpc_q;

  logic        irq_take;
  logic        accept;
  logic        take_mret;
  logic [31:0] cause_new, val_new, pc_new;

  // rst_n gates acceptance so the comb outputs read 0 during reset
  assign irq_take  = irq_pending & wb_valid;
  assign accept    = rst_n & (state_q == IDLE)
                   & (exc_req | mret_req | irq_take);
  assign take_mret = mret_req & ~exc_req;

  assign cause_new = exc_req ? {28'b0, exc_code}
                   : ext_irq ? 32'h8000_000B
                   : 32'h8000_0007;
  assign val_new   = exc_req ? exc_tval : 32'h0;
  assign pc_new    = exc_req ? exc_pc : wb_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_mret_q <= 1'b0;
      cause_q   <= 32'h0;
      val_q     <= 32'h0;
      pc_q      <= 32'h0;
      rpc_q     <= 32'h0;
    end else begin
      if (accept) begin
        is_mret_q <= take_mret;
        cause_q   <= cause_new;
        val_q     <= val_new;
        pc_q      <= pc_new;
      end
      // target frozen here so it stays stable while fetch stalls
      if (state_q == COMMIT) begin
        rpc_q <= is_mret_q ? mepc
                           : (mtvec & 32'hFFFF_FFFC);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = mem_busy ? DRAIN : COMMIT;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trap_enter     = 1'b0;
    mret           = 1'b0;
    trap_cause     = 32'h0;
    trap_val       = 32'h0;
    trap_pc        = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    busy           = (state_q != IDLE);
    flush          = accept | busy;
    // MRET retires normally, so only traps kill WB
    wb_kill        = accept & ~take_mret;
    if (state_q == COMMIT) begin
      trap_enter = ~is_mret_q;
      mret       = is_mret_q;
      if (!is_mret_q) begin
        trap_cause = cause_q;
        trap_val   = val_q;
        trap_pc    = pc_q;
      end
    end
    if (state_q == REDIRECT) begin
      redirect_valid = 1'b1;
      redirect_pc    = rpc_q;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed + random stimulus against a
// transaction-level model of the trap sequencer.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_req, mret_req, wb_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, wb_pc;
  logic        irq_pending, ext_irq, timer_irq;
  logic [31:0] mtvec, mepc;
  logic        mem_busy, redirect_ready;
  logic        trap_enter, mret, wb_kill, flush;
  logic        redirect_valid, busy;
  logic [31:0] trap_cause, trap_val, trap_pc, redirect_pc;

  int n_chk  = 0;
  int n_pass = 0;

  // model: one in-flight event and where it is in its life
  bit          m_act, m_com, m_red, m_mret;
  logic [31:0] m_cause, m_val, m_pc, m_rpc;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exc_req(exc_req), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .irq_pending(irq_pending),
    .ext_irq(ext_irq), .timer_irq(timer_irq),
    .mtvec(mtvec), .mepc(mepc),
    .mem_busy(mem_busy),
    .redirect_ready(redirect_ready),
    .trap_enter(trap_enter),
    .trap_cause(trap_cause),
    .trap_val(trap_val), .trap_pc(trap_pc),
    .mret(mret), .wb_kill(wb_kill),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic model_reset();
    m_act = 0; m_com = 0; m_red = 0; m_mret = 0;
  endtask

  function automatic bit any_event();
    return exc_req || mret_req
        || (irq_pending && wb_valid);
  endfunction

  task automatic check_all();
    bit acc, mr, te, mo;
    acc = rst_n && !m_act && any_event();
    mr  = mret_req && !exc_req;
    te  = m_act && m_com && !m_mret;
    mo  = m_act && m_com && m_mret;
    check("wb_kill", 32'(wb_kill), 32'(acc && !mr));
    check("flush", 32'(flush), 32'(acc || m_act));
    check("busy", 32'(busy), 32'(m_act));
    check("trap_enter", 32'(trap_enter), 32'(te));
    check("mret", 32'(mret), 32'(mo));
    check("cause", trap_cause, te ? m_cause : 0);
    check("tval", trap_val, te ? m_val : 0);
    check("tpc", trap_pc, te ? m_pc : 0);
    check("rvalid", 32'(redirect_valid), 32'(m_red));
    check("rpc", redirect_pc, m_red ? m_rpc : 0);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_act) begin
      if (any_event()) begin
        m_act  = 1;
        m_red  = 0;
        m_mret = mret_req && !exc_req;
        if (exc_req) begin
          m_cause = {28'b0, exc_code};
          m_val   = exc_tval;
          m_pc    = exc_pc;
        end else if (!mret_req) begin
          m_cause = ext_irq ? 32'h8000000B
                            : 32'h80000007;
          m_val   = 0;
          m_pc    = wb_pc;
        end
        m_com = !mem_busy;
      end
    end else if (m_red) begin
      if (redirect_ready) begin
        m_act = 0;
        m_red = 0;
      end
    end else if (m_com) begin
      m_com = 0;
      m_red = 1;
      m_rpc = m_mret ? mepc : (mtvec & ~32'd3);
    end else if (!mem_busy) begin
      m_com = 1;
    end
  endtask

  // inputs already driven; check mid-cycle, advance both
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr();
    exc_req = 0; mret_req = 0; irq_pending = 0;
    wb_valid = 0; ext_irq = 0; timer_irq = 0;
    mem_busy = 0; redirect_ready = 0;
    exc_code = 0; exc_pc = 0; exc_tval = 0;
    wb_pc = 0;
  endtask

  task automatic rand_in();
    exc_req        = ($urandom_range(4) == 0);
    mret_req       = ($urandom_range(4) == 0);
    irq_pending    = ($urandom_range(2) == 0);
    wb_valid       = ($urandom_range(1) == 0);
    ext_irq        = ($urandom_range(1) == 0);
    timer_irq      = ($urandom_range(1) == 0);
    if (!ext_irq) timer_irq = 1;
    mem_busy       = ($urandom_range(1) == 0);
    redirect_ready = ($urandom_range(1) == 0);
    exc_code       = 4'($urandom);
    exc_pc         = $urandom;
    exc_tval       = $urandom;
    wb_pc          = $urandom;
    mtvec          = $urandom;
    mepc           = $urandom;
  endtask

  initial begin
    rst_n = 0;
    mtvec = 0; mepc = 0;
    model_reset();
    rand_in();
    exc_req = 1;
    step();
    step();
    rst_n = 1;

    // exception, no drain
    clr();
    exc_req = 1; exc_code = 2; exc_pc = 32'h100;
    exc_tval = 32'h13; mtvec = 32'h200;
    #1 check("t23_kill", 32'(wb_kill), 1);
    step();
    clr();
    #1 check("t23_te", 32'(trap_enter), 1);
    check("t23_cause", trap_cause, 32'h2);
    check("t23_pc", trap_pc, 32'h100);
    check("t23_val", trap_val, 32'h13);
    step();
    #1 check("t23_rv", 32'(redirect_valid), 1);
    check("t23_rpc", redirect_pc, 32'h200);
    redirect_ready = 1;
    step();

    // interrupt, ext wins
    clr();
    irq_pending = 1; ext_irq = 1; timer_irq = 1;
    wb_valid = 1; wb_pc = 32'h400;
    step();
    clr();
    #1 check("t24_cause", trap_cause, 32'h8000000B);
    check("t24_pc", trap_pc, 32'h400);
    check("t24_val", trap_val, 0);
    step();
    redirect_ready = 1;
    step();

    // mret
    clr();
    mret_req = 1; mepc = 32'h104;
    #1 check("t25_kill", 32'(wb_kill), 0);
    step();
    clr();
    #1 check("t25_mret", 32'(mret), 1);
    check("t25_te", 32'(trap_enter), 0);
    step();
    #1 check("t25_mret_off", 32'(mret), 0);
    check("t25_rpc", redirect_pc, 32'h104);
    redirect_ready = 1;
    step();

    // drain for three cycles
    clr();
    exc_req = 1; mem_busy = 1;
    step();
    exc_req = 0;
    step();
    step();
    mem_busy = 0;
    #1 check("t26_wait", 32'(trap_enter), 0);
    check("t26_busy", 32'(busy), 1);
    step();
    #1 check("t26_te", 32'(trap_enter), 1);
    step();
    #1 check("t26_once", 32'(trap_enter), 0);
    redirect_ready = 1;
    step();

    // redirect stall, requests ignored
    clr();
    exc_req = 1; mtvec = 32'h303;
    step();
    exc_req = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      exc_req = 1; exc_code = 4'($urandom);
      step();
      check("t27_rpc", redirect_pc, 32'h300);
    end
    clr();
    redirect_ready = 1;
    step();
    #1 check("t27_idle", 32'(busy), 0);

    // reset mid-drain
    clr();
    exc_req = 1; mem_busy = 1;
    step();
    exc_req = 0;
    step();
    #1 rst_n = 0;
    #1 model_reset();
    check_all();
    check("t28_busy", 32'(busy), 0);
    check("t28_flush", 32'(flush), 0);
    mem_busy = 0;
    step();
    rst_n = 1;
    step();
    step();
    check("t28_nte", 32'(trap_enter), 0);

    for (int i = 0; i < 500; i++) begin
      rand_in();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; rst_n  in  1  asynchronous active-low reset (one clock, reset asynchronous active-low, as already decided).
REQ-002 SHALL have inputs: exc_req 1 (WB exception); exc_code 4 (exception code); exc_pc 32; exc_tval 32; mret_req 1 (MRET in WB); wb_valid 1 (valid instruction in WB); wb_pc 32.
REQ-003 SHALL have inputs: irq_pending 1; ext_irq 1; timer_irq 1; mtvec 32; mepc 32 (all from CSR unit); mem_busy 1 (outstanding data-bus transaction); redirect_ready 1 (fetch accepts redirect).
REQ-004 SHALL have outputs: trap_enter 1; trap_cause 32; trap_val 32; trap_pc 32; mret 1 (to CSR unit); wb_kill 1 (suppress WB retire/writeback); flush 1 (flush IF..MEM); redirect_valid 1; redirect_pc 32; busy 1 (state != IDLE).

Function
REQ-005 SHALL implement FSM states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-006 In IDLE, SHALL accept one event per cycle with priority exc_req > mret_req > interrupt (irq_pending & wb_valid).
REQ-007 Interrupt cause SHALL be 0x8000000B if ext_irq, else 0x80000007 if timer_irq; ext wins when both set.
REQ-008 Exception cause SHALL be {28'b0, exc_code}; trap_val = exc_tval; trap_pc = exc_pc.
REQ-009 Interrupt SHALL capture trap_pc = wb_pc, trap_val = 0.
REQ-010 On acceptance, SHALL register cause/val/pc/kind; next state DRAIN if mem_busy else COMMIT.
REQ-011 wb_kill SHALL be combinational, high in the IDLE acceptance cycle for exception or interrupt only; never for MRET (MRET retires).
REQ-012 flush SHALL be high in the acceptance cycle and in every non-IDLE state.
REQ-013 DRAIN SHALL hold until mem_busy == 0, then go to COMMIT next cycle.
REQ-014 COMMIT SHALL last exactly one cycle: trap_enter = 1 for trap kinds, or mret = 1 for MRET; never both; then REDIRECT.
REQ-015 trap_cause/trap_val/trap_pc SHALL hold registered values whenever trap_enter is high; otherwise 0.
REQ-016 REDIRECT SHALL assert redirect_valid with redirect_pc = {mtvec[31:2],2'b00} for traps or mepc for MRET, sampled on COMMIT->REDIRECT transition and held stable.
REQ-017 redirect_valid SHALL stay high until redirect_ready; on handshake cycle return to IDLE.
REQ-018 All exc_req, mret_req, irq_pending SHALL be ignored while busy (pipeline being flushed); no queuing.
REQ-019 Minimum latency acceptance->redirect_valid SHALL be 2 cycles (IDLE->COMMIT->REDIRECT); a new event SHALL be acceptable in the cycle after the handshake.
REQ-020 exc_req with wb_valid = 0 SHALL still be accepted; interrupt SHALL require wb_valid = 1.

Reset
REQ-021 On rst_n low, SHALL enter IDLE asynchronously, clear all captured registers, and drive every output 0, including mid-DRAIN/REDIRECT (no trap_enter/mret pulse on reset exit).
REQ-022 After rst_n deasserts, the first event SHALL be acceptable on the first clock edge.

Verification
REQ-023 exc_req=1, exc_code=2, exc_pc=0x100, exc_tval=0x13, mem_busy=0, mtvec=0x200 -> wb_kill same cycle; trap_enter next cycle with cause 0x2, pc 0x100, val 0x13; redirect_valid/redirect_pc=0x200 cycle after.
REQ-024 irq_pending=1, ext_irq=1, timer_irq=1, wb_valid=1, wb_pc=0x400 -> trap_cause 0x8000000B, trap_pc 0x400, trap_val 0.
REQ-025 mret_req=1, mepc=0x104 -> wb_kill=0, mret pulse 1 cycle, trap_enter=0, redirect_pc 0x104.
REQ-026 exc_req with mem_busy=1 for 3 cycles -> DRAIN 3 cycles, trap_enter exactly one cycle after mem_busy falls.
REQ-027 redirect_ready low 4 cycles, new exc_req asserted meanwhile -> redirect_valid/pc held stable, second request ignored, IDLE after handshake.
REQ-028 rst_n asserted during DRAIN -> all outputs 0 immediately; no trap_enter after release.
